capture_fifo_apb: RTL and testbench

//  Downstream consumer of the counter/shift-and-save capture path. Buffers captured 32-bit count

---
 rtl/capture_fifo_pkg.sv | 31 +++
 rtl/sync_fifo_core.sv | 61 ++++++
 rtl/capture_fifo_apb.sv | 143 ++++++++++++++
 tb/tb_capture_fifo_apb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/capture_fifo_pkg.sv
// Shared register map, bit positions and control-register layout for the
// capture FIFO APB slave.
package capture_fifo_pkg;

  // Word offsets, compared against PADDR[3:2]
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_UDF   = 11;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_THRESH_LO = 8;
  localparam int CTRL_THRESH_HI = 15;

  localparam int CMD_FLUSH   = 0;
  localparam int CMD_CLR_OVF = 1;
  localparam int CMD_CLR_UDF = 2;

  typedef struct packed {
    logic       en;
    logic       irq_en;
    logic [7:0] thresh;
  } ctrl_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// Push is accepted when full only if a pop happens in the same cycle; flush wins over both.
module sync_fifo_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Storage carries no reset; only pointers and count are control state
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/capture_fifo_apb.sv
// APB3 slave buffering captured count snapshots in a FIFO; DATA reads pop,
// with status, control, command and a level interrupt on threshold or overflow.
module capture_fifo_apb
  import capture_fifo_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int THRESH0 = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [15:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);

  ctrl_t             ctrl;
  logic              ovf;
  logic              udf;
  logic [DATA_W-1:0] head;
  logic [AW:0]       count;
  logic [7:0]        count_ext;
  logic              full;
  logic              empty;

  logic              setup;
  logic              access;
  logic              mapped;
  logic [1:0]        sel;
  logic              err;
  logic              pop;
  logic              udf_set;
  logic              ctrl_wr;
  logic              cmd_wr;
  logic              flush;
  logic              push;
  logic              ovf_set;
  logic [DATA_W-1:0] rd_val;
  logic              unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA[DATA_W-1:16], PWDATA[7:3]};

  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;
  assign mapped = (PADDR[15:4] == '0);
  assign sel    = PADDR[3:2];

  always_comb begin
    err = 1'b0;
    if (!mapped)     err = 1'b1;
    else if (PWRITE) err = (sel == ADDR_DATA) | (sel == ADDR_STATUS);
    else             err = (sel == ADDR_CMD) | ((sel == ADDR_DATA) & empty);
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = access & err;

  assign pop     = access & ~PWRITE & mapped & (sel == ADDR_DATA) & ~empty;
  assign udf_set = access & ~PWRITE & mapped & (sel == ADDR_DATA) & empty;
  assign ctrl_wr = access & PWRITE & mapped & (sel == ADDR_CTRL);
  assign cmd_wr  = access & PWRITE & mapped & (sel == ADDR_CMD);
  assign flush   = cmd_wr & PWDATA[CMD_FLUSH];
  assign push    = cap_valid & ctrl.en;
  // A capture into a full FIFO survives only when a pop frees the slot the same cycle
  assign ovf_set = push & full & ~pop & ~flush;

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (cap_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign count_ext = 8'(count);

  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (sel)
        ADDR_DATA:   if (!empty) rd_val = head;
        ADDR_STATUS: begin
          rd_val[AW:0]     = count;
          rd_val[ST_EMPTY] = empty;
          rd_val[ST_FULL]  = full;
          rd_val[ST_OVF]   = ovf;
          rd_val[ST_UDF]   = udf;
        end
        ADDR_CTRL: begin
          rd_val[CTRL_EN]                        = ctrl.en;
          rd_val[CTRL_IRQ_EN]                    = ctrl.irq_en;
          rd_val[CTRL_THRESH_HI:CTRL_THRESH_LO]  = ctrl.thresh;
        end
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl   <= '{en: 1'b0, irq_en: 1'b0, thresh: 8'(THRESH0)};
      ovf    <= 1'b0;
      udf    <= 1'b0;
      PRDATA <= '0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl.en     <= PWDATA[CTRL_EN];
        ctrl.irq_en <= PWDATA[CTRL_IRQ_EN];
        ctrl.thresh <= PWDATA[CTRL_THRESH_HI:CTRL_THRESH_LO];
      end
      // A new event in the same cycle as its clear command leaves the flag set
      if (ovf_set)                              ovf <= 1'b1;
      else if (cmd_wr && PWDATA[CMD_CLR_OVF])   ovf <= 1'b0;
      if (udf_set)                              udf <= 1'b1;
      else if (cmd_wr && PWDATA[CMD_CLR_UDF])   udf <= 1'b0;
      // Read data is captured in the setup cycle and held through the access cycle
      if (setup && !PWRITE)                     PRDATA <= rd_val;
      else if (!(access && !PWRITE))            PRDATA <= '0;
      irq <= ctrl.irq_en &
             (((ctrl.thresh != 8'd0) && (count_ext >= ctrl.thresh)) | ovf);
    end
  end

endmodule

// File: tb/tb_capture_fifo_apb.sv
// Directed bench for capture_fifo_apb: APB transfers push expected responses to a
// scoreboard queue that a monitor checks in each access phase.
module tb_capture_fifo_apb;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_data = '0;
  logic        irq;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seq     = 0;

  always #5 PCLK = ~PCLK;

  capture_fifo_apb #(.DATA_W(32), .DEPTH(16), .THRESH0(8)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .irq       (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every access phase must match the oldest queued expectation
  always @(negedge PCLK) begin
    if (PRESETn && PSEL && PENABLE) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: access phase at addr 0x%04h with no expectation", PADDR);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.wr) chk($sformatf("apb%0d_prdata", mon_e.tag), PRDATA, mon_e.data);
        chk($sformatf("apb%0d_pslverr", mon_e.tag), {31'd0, PSLVERR}, {31'd0, mon_e.err});
        chk($sformatf("apb%0d_pready", mon_e.tag), {31'd0, PREADY}, 32'd1);
      end
    end
  end

  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic cap_en, input logic [31:0] cap_d);
    sb.push_back('{wr: wr, data: exp_rd, err: exp_err, tag: seq});
    seq++;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (cap_en) begin
      cap_valid = 1'b1;
      cap_data  = cap_d;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    cap_valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    apb(1'b0, addr, 32'd0, exp_rd, exp_err, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic exp_err);
    apb(1'b1, addr, data, 32'd0, exp_err, 1'b0, 32'd0);
  endtask

  task automatic cap(input logic [31:0] d);
    @(posedge PCLK); #1;
    cap_valid = 1'b1; cap_data = d;
    @(posedge PCLK); #1;
    cap_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Reset state
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(16'h4, 32'h0000_0100, 1'b0);
    rd(16'h8, 32'h0000_0800, 1'b0);

    // Threshold interrupt: en, irq_en, thresh=3
    wr(16'h8, 32'h0000_0303, 1'b0);
    rd(16'h8, 32'h0000_0303, 1'b0);
    cap(32'h11); cap(32'h22); cap(32'h33);
    chk("thr_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("thr_irq_set", {31'd0, irq}, 32'd1);
    rd(16'h4, 32'h0000_0003, 1'b0);
    rd(16'h0, 32'h11, 1'b0);
    tick();
    chk("thr_irq_drain", {31'd0, irq}, 32'd0);
    rd(16'h0, 32'h22, 1'b0);
    rd(16'h0, 32'h33, 1'b0);
    rd(16'h4, 32'h0000_0100, 1'b0);

    // Overflow: thresh=0 so only ovf can raise irq
    wr(16'h8, 32'h0000_0003, 1'b0);
    for (int i = 1; i <= 17; i++) cap(32'h100 + i);
    rd(16'h4, 32'h0000_0610, 1'b0);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    rd(16'h0, 32'h101, 1'b0);
    rd(16'h4, 32'h0000_040F, 1'b0);
    wr(16'hC, 32'h2, 1'b0);
    rd(16'h4, 32'h0000_000F, 1'b0);
    chk("ovf_irq_clr", {31'd0, irq}, 32'd0);
    wr(16'hC, 32'h1, 1'b0);
    rd(16'h4, 32'h0000_0100, 1'b0);

    // Underflow
    rd(16'h0, 32'h0, 1'b1);
    rd(16'h4, 32'h0000_0900, 1'b0);
    wr(16'hC, 32'h4, 1'b0);
    rd(16'h4, 32'h0000_0100, 1'b0);

    // Full FIFO, capture coincident with a pop
    for (int i = 0; i < 16; i++) cap(32'h200 + i);
    rd(16'h4, 32'h0000_0210, 1'b0);
    apb(1'b0, 16'h0, 32'd0, 32'h200, 1'b0, 1'b1, 32'hABC);
    rd(16'h4, 32'h0000_0210, 1'b0);
    for (int i = 1; i < 16; i++) rd(16'h0, 32'h200 + i, 1'b0);
    rd(16'h0, 32'hABC, 1'b0);
    rd(16'h4, 32'h0000_0100, 1'b0);
    chk("full_pop_irq", {31'd0, irq}, 32'd0);

    // Error responses without state change
    wr(16'h4, 32'hFFFF_FFFF, 1'b1);
    wr(16'h0, 32'h1234, 1'b1);
    wr(16'h18, 32'h0000_0000, 1'b1);
    rd(16'h10, 32'h0, 1'b1);
    rd(16'hC, 32'h0, 1'b1);
    rd(16'h4, 32'h0000_0100, 1'b0);
    rd(16'h8, 32'h0000_0003, 1'b0);

    // Flush with a coincident capture
    cap(32'h1); cap(32'h2);
    rd(16'h4, 32'h0000_0002, 1'b0);
    apb(1'b1, 16'hC, 32'h1, 32'd0, 1'b0, 1'b1, 32'h3);
    rd(16'h4, 32'h0000_0100, 1'b0);

    // Capture disabled
    wr(16'h8, 32'h0000_0000, 1'b0);
    cap(32'h5);
    rd(16'h4, 32'h0000_0100, 1'b0);
    rd(16'h8, 32'h0000_0000, 1'b0);

    tick(); tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
